// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the stack engine and its neighbours.
//   STACK_TOP / STACK_LIMIT : empty-stack ESP (also the ESP register reset value)
//                             and the lowest legal pushed address.
//   ESP_WR_CMD              : write command understood by the ESP register.
//   OP_* / FAULT_*          : micro-op and fault encodings.
//   state_t                 : stack engine FSM states.
package cpu_pkg;

    localparam logic [31:0] STACK_TOP   = 32'h000fffff;
    localparam logic [31:0] STACK_LIMIT = 32'h000f0000;

    localparam logic [3:0]  ESP_WR_CMD  = 4'h2;
    localparam logic [3:0]  ESP_NO_CMD  = 4'h0;

    localparam logic [1:0]  OP_PUSH     = 2'b01;
    localparam logic [1:0]  OP_POP      = 2'b10;

    localparam logic [1:0]  FAULT_NONE      = 2'b00;
    localparam logic [1:0]  FAULT_OVERFLOW  = 2'b01;
    localparam logic [1:0]  FAULT_UNDERFLOW = 2'b10;
    localparam logic [1:0]  FAULT_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMem,
        StCommit,
        StFault
    } state_t;

endpackage

// File: rtl/stack_bounds_check.sv
// stack_bounds_check: combinational ESP arithmetic and bounds check for one op.
//   esp_in     in   current ESP
//   op_code    in   micro-op (PUSH / POP / illegal)
//   new_esp    out  ESP after the op completes
//   mem_addr   out  byte address of the memory access
//   fault_code out  FAULT_NONE when the op may proceed, otherwise the reason
module stack_bounds_check
    import cpu_pkg::*;
(
    input  logic [31:0] esp_in,
    input  logic [1:0]  op_code,
    output logic [31:0] new_esp,
    output logic [31:0] mem_addr,
    output logic [1:0]  fault_code
);

    // Extra top bit captures the borrow when esp_in < 4.
    logic [32:0] push_diff;
    assign push_diff = {1'b0, esp_in} - 33'd4;

    always_comb begin
        new_esp    = esp_in;
        mem_addr   = esp_in;
        fault_code = FAULT_NONE;
        case (op_code)
            OP_PUSH: begin
                new_esp  = push_diff[31:0];
                mem_addr = push_diff[31:0];
                if (push_diff[32] || (push_diff[31:0] < STACK_LIMIT)) begin
                    fault_code = FAULT_OVERFLOW;
                end
            end
            OP_POP: begin
                new_esp  = esp_in + 32'd4;
                mem_addr = esp_in;
                if (esp_in >= STACK_TOP) begin
                    fault_code = FAULT_UNDERFLOW;
                end
            end
            default: begin
                fault_code = FAULT_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/stack_engine.sv
// stack_engine: executes PUSH/POP micro-ops and owns every stack pointer update.
//   clock_5, reset          clock and synchronous active-low reset
//   op_valid/op_ready       op handshake; op_code, push_data, esp_in sampled at accept
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack
//                           single 32-bit memory access, req held until ack
//   esp_cmd/esp_wdata       ESP register write (ESP_WR_CMD for one cycle)
//   done/pop_data           completion pulse; pop_data held until the next POP
//   fault/fault_code        rejection pulse; fault_code held until the next fault
module stack_engine
    import cpu_pkg::*;
(
    input  logic        clock_5,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [31:0] push_data,
    input  logic [31:0] esp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  esp_cmd,
    output logic [31:0] esp_wdata,
    output logic        done,
    output logic [31:0] pop_data,
    output logic        fault,
    output logic [1:0]  fault_code
);

    state_t      state;
    logic [31:0] new_esp_q;

    logic [31:0] chk_new_esp;
    logic [31:0] chk_addr;
    logic [1:0]  chk_fault;

    stack_bounds_check u_bounds (
        .esp_in     (esp_in),
        .op_code    (op_code),
        .new_esp    (chk_new_esp),
        .mem_addr   (chk_addr),
        .fault_code (chk_fault)
    );

    always_ff @(posedge clock_5) begin
        if (!reset) begin
            state      <= StIdle;
            op_ready   <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            esp_cmd    <= ESP_NO_CMD;
            esp_wdata  <= 32'h0;
            done       <= 1'b0;
            pop_data   <= 32'h0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            new_esp_q  <= 32'h0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (op_valid) begin
                        op_ready <= 1'b0;
                        if (chk_fault != FAULT_NONE) begin
                            fault      <= 1'b1;
                            fault_code <= chk_fault;
                            state      <= StFault;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= (op_code == OP_PUSH);
                            mem_addr  <= chk_addr;
                            new_esp_q <= chk_new_esp;
                            if (op_code == OP_PUSH) begin
                                mem_wdata <= push_data;
                            end
                            state <= StMem;
                        end
                    end
                end
                StMem: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            pop_data <= mem_rdata;
                        end
                        // ESP write and done are registered so they appear in COMMIT.
                        esp_cmd   <= ESP_WR_CMD;
                        esp_wdata <= new_esp_q;
                        done      <= 1'b1;
                        state     <= StCommit;
                    end
                end
                StCommit: begin
                    esp_cmd  <= ESP_NO_CMD;
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= StIdle;
                end
                StFault: begin
                    fault    <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed + randomized checks of stack_engine against a
// behavioural model (ESP as a plain number, memory as an associative array).
module tb_stack_engine;

    logic        clock_5 = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] push_data = 32'h0;
    logic [31:0] esp_in = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [3:0]  esp_cmd;
    logic [31:0] esp_wdata;
    logic        done;
    logic [31:0] pop_data;
    logic        fault;
    logic [1:0]  fault_code;

    stack_engine dut (
        .clock_5    (clock_5),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .push_data  (push_data),
        .esp_in     (esp_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .esp_cmd    (esp_cmd),
        .esp_wdata  (esp_wdata),
        .done       (done),
        .pop_data   (pop_data),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clock_5 = ~clock_5;

    localparam longint TOP   = 64'h000fffff;
    localparam longint LIMIT = 64'h000f0000;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] model_esp;
    logic [31:0] last_pop;
    logic [1:0]  last_fault;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic wait_ready();
        int k = 0;
        while (op_ready !== 1'b1 && k < 20) begin
            @(negedge clock_5);
            k++;
        end
        if (op_ready !== 1'b1) check_eq("ready_timeout", {31'b0, op_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] code, input logic [31:0] data,
                          input logic [31:0] esp, input int ack_wait);
        longint      e = longint'(esp);
        bit          is_push = (code == 2'b01);
        bit          is_pop = (code == 2'b10);
        logic [1:0]  exp_code = 2'b00;
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_new = 32'h0;
        logic [31:0] rdata;

        if (is_push) begin
            if (e - 4 < LIMIT) exp_code = 2'b01;
            exp_addr = 32'(e - 4);
            exp_new  = exp_addr;
        end else if (is_pop) begin
            if (e >= TOP) exp_code = 2'b10;
            exp_addr = esp;
            exp_new  = 32'(e + 4);
        end else begin
            exp_code = 2'b11;
        end

        wait_ready();
        op_valid  = 1'b1;
        op_code   = code;
        push_data = data;
        esp_in    = esp;
        @(posedge clock_5);
        #1;
        op_valid  = 1'b0;
        op_code   = 2'($urandom);
        esp_in    = $urandom;
        push_data = $urandom;
        @(negedge clock_5);

        if (exp_code != 2'b00) begin
            last_fault = exp_code;
            check_eq("fault_pulse", {31'b0, fault}, 32'd1);
            check_eq("fault_code", {30'b0, fault_code}, {30'b0, exp_code});
            check_eq("fault_no_req", {31'b0, mem_req}, 32'd0);
            check_eq("fault_no_esp", {28'b0, esp_cmd}, 32'd0);
            @(negedge clock_5);
            check_eq("fault_end", {31'b0, fault}, 32'd0);
            check_eq("fault_ready", {31'b0, op_ready}, 32'd1);
            check_eq("fault_code_hold", {30'b0, fault_code}, {30'b0, last_fault});
        end else begin
            check_eq("mem_req", {31'b0, mem_req}, 32'd1);
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, is_push});
            check_eq("mem_addr", mem_addr, exp_addr);
            if (is_push) check_eq("mem_wdata", mem_wdata, data);
            check_eq("busy_ready", {31'b0, op_ready}, 32'd0);
            if (is_pop) rdata = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : $urandom;
            else        rdata = $urandom;
            for (int w = 0; w < ack_wait; w++) begin
                mem_rdata = $urandom;
                @(negedge clock_5);
                check_eq("mem_req_hold", {31'b0, mem_req}, 32'd1);
                check_eq("mem_addr_hold", mem_addr, exp_addr);
            end
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            @(posedge clock_5);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            @(negedge clock_5);
            if (is_pop) last_pop = rdata;
            else ref_mem[exp_addr] = data;
            check_eq("done", {31'b0, done}, 32'd1);
            check_eq("esp_cmd", {28'b0, esp_cmd}, 32'h2);
            check_eq("esp_wdata", esp_wdata, exp_new);
            check_eq("req_drop", {31'b0, mem_req}, 32'd0);
            check_eq("pop_data", pop_data, last_pop);
            model_esp = exp_new;
            @(negedge clock_5);
            check_eq("done_end", {31'b0, done}, 32'd0);
            check_eq("esp_cmd_end", {28'b0, esp_cmd}, 32'd0);
            check_eq("ready_again", {31'b0, op_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [1:0]  code;
        logic [31:0] esp;

        // Reset
        reset = 1'b0;
        repeat (2) @(posedge clock_5);
        @(negedge clock_5);
        check_eq("rst_ready", {31'b0, op_ready}, 32'd1);
        check_eq("rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_we", {31'b0, mem_we}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_esp_cmd", {28'b0, esp_cmd}, 32'h0);
        check_eq("rst_esp_wdata", esp_wdata, 32'h0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_pop", pop_data, 32'h0);
        check_eq("rst_fault", {31'b0, fault}, 32'd0);
        check_eq("rst_fcode", {30'b0, fault_code}, 32'd0);
        reset      = 1'b1;
        model_esp  = 32'h000fffff;
        last_pop   = 32'h0;
        last_fault = 2'b00;

        // Directed cases
        run_op(2'b01, 32'hdeadbeef, 32'h000fffff, 0);
        run_op(2'b10, 32'h0, 32'h000ffffb, 3);
        run_op(2'b10, 32'h0, 32'h000fffff, 0);
        run_op(2'b01, 32'h11111111, 32'h000f0003, 0);
        run_op(2'b01, 32'h12345678, 32'h000f0004, 1);
        run_op(2'b11, 32'h0, 32'h000ffff0, 0);
        run_op(2'b00, 32'h0, 32'h000ffff0, 0);
        run_op(2'b01, 32'h0badf00d, 32'h00000002, 0);

        // Stray ack in IDLE
        mem_ack = 1'b1;
        @(posedge clock_5);
        #1 mem_ack = 1'b0;
        @(negedge clock_5);
        check_eq("stray_ready", {31'b0, op_ready}, 32'd1);
        check_eq("stray_req", {31'b0, mem_req}, 32'd0);
        check_eq("stray_done", {31'b0, done}, 32'd0);
        check_eq("stray_esp", {28'b0, esp_cmd}, 32'd0);

        // Reset while in MEM
        wait_ready();
        op_valid  = 1'b1;
        op_code   = 2'b01;
        push_data = 32'hcafef00d;
        esp_in    = 32'h000fffff;
        @(posedge clock_5);
        #1 op_valid = 1'b0;
        @(negedge clock_5);
        check_eq("mid_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b0;
        @(posedge clock_5);
        #1 reset = 1'b1;
        @(negedge clock_5);
        check_eq("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("mid_rst_done", {31'b0, done}, 32'd0);
        check_eq("mid_rst_esp", {28'b0, esp_cmd}, 32'd0);
        check_eq("mid_rst_ready", {31'b0, op_ready}, 32'd1);
        mem_ack = 1'b1;
        @(posedge clock_5);
        #1 mem_ack = 1'b0;
        @(negedge clock_5);
        check_eq("late_ack_done", {31'b0, done}, 32'd0);
        check_eq("late_ack_esp", {28'b0, esp_cmd}, 32'd0);
        check_eq("late_ack_req", {31'b0, mem_req}, 32'd0);
        model_esp  = 32'h000fffff;
        last_pop   = 32'h0;
        last_fault = 2'b00;
        ref_mem.delete();
        run_op(2'b01, 32'ha5a5a5a5, model_esp, 2);

        // Randomized ops against the model
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0: code = 2'b00;
                1: code = 2'b11;
                2, 3, 4, 5: code = 2'b01;
                default: code = 2'b10;
            endcase
            case ($urandom_range(0, 9))
                0: esp = 32'h000f0000 + $urandom_range(0, 8);
                1: esp = 32'h000fffff - $urandom_range(0, 8);
                2: esp = $urandom_range(0, 7);
                3: esp = 32'hfffffffc + $urandom_range(0, 3);
                default: esp = model_esp;
            endcase
            run_op(code, $urandom, esp, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_engine.md
# stack_engine

Executes PUSH and POP micro-operations for the CPU core and owns every update of the stack pointer. It samples the current ESP, checks stack bounds, performs one 32-bit memory access through a req/ack handshake, then writes the new ESP value into the ESP register using that register's existing write command. It sits between the decode/execute sequencer, the data-memory port and the ESP register.

## Interface
- STACK_TOP, 32'h000fffff: ESP value when the stack is empty; equals the ESP register reset value.
- STACK_LIMIT, 32'h000f0000: lowest legal pushed address.
- ESP_WR_CMD, 4'h2: ESP register write command code.
- clock_5  in  1  sole clock; all logic is on the posedge.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  high only in IDLE; an op is accepted when op_valid && op_ready.
- op_code  in  2  01 = PUSH, 10 = POP, 00/11 = illegal.
- push_data  in  32  value to push; sampled at accept.
- esp_in  in  32  current ESP from the ESP register; sampled at accept.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write (PUSH), 0 = read (POP).
- mem_addr  out  32  byte address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- esp_cmd  out  4  ESP_WR_CMD during COMMIT, else 4'h0.
- esp_wdata  out  32  new ESP value.
- done  out  1  one-cycle pulse on successful completion.
- pop_data  out  32  popped value; valid while done=1 and held until the next POP completes.
- fault  out  1  one-cycle pulse on a rejected op.
- fault_code  out  2  01 = overflow, 10 = underflow, 11 = illegal; held until the next fault.

## Operation
- States: IDLE, MEM, COMMIT, FAULT.
- Reset (reset=0 at a posedge): state IDLE, op_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, esp_cmd=0, esp_wdata=0, done=0, pop_data=0, fault=0, fault_code=0.
- IDLE, accept PUSH: compute new_esp = esp_in - 4 (32-bit, wrapping).
  - If new_esp < STACK_LIMIT or the subtraction borrows: go to FAULT with code 01.
  - Otherwise: mem_addr=new_esp, mem_we=1, mem_wdata=push_data; go to MEM.
- IDLE, accept POP:
  - If esp_in >= STACK_TOP: go to FAULT with code 10.
  - Otherwise: mem_addr=esp_in, mem_we=0, new_esp = esp_in + 4; go to MEM.
- IDLE, illegal op_code: accept, then go to FAULT with code 11.
- MEM: mem_req=1 with mem_addr, mem_we and mem_wdata held stable. On mem_ack: capture mem_rdata (POP only), deassert mem_req, go to COMMIT.
- COMMIT (one cycle): esp_cmd=ESP_WR_CMD, esp_wdata=new_esp, done=1; POP drives the captured value on pop_data. Go to IDLE.
- FAULT (one cycle): fault=1 with fault_code. No memory access, ESP unchanged. Go to IDLE.
- mem_ack outside MEM is ignored.
- Addresses are not alignment-checked.

## Timing
- Accept at edge T. mem_req is high from cycle T+1.
- mem_ack at cycle A (A >= T+1): COMMIT/done in cycle A+1; op_ready high again in A+2.
- Best case: 3 cycles from accept to next accept.
- Fault path: fault in T+1, op_ready high in T+2.
- esp_in is ignored after accept. The ESP register updates at the end of the COMMIT edge, so a back-to-back op accepted in A+2 sees the new ESP.
- Reset mid-operation: next edge returns to IDLE with mem_req=0 and no ESP write. A late mem_ack after reset is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_PUSH and OP_POP;
  - ESP_WR_CMD;
  - fault code constants;
  - the state enum typedef;
  - STACK_TOP and STACK_LIMIT defaults, shared with the ESP register reset value.
- One sub-module, stack_bounds_check (combinational): inputs esp_in and op_code; outputs new_esp, mem address and fault_code.

## Test plan
- Reset, then PUSH 32'hdeadbeef with esp_in=32'h000fffff and ack 0 wait -> mem write at 32'h000ffffb with data 32'hdeadbeef; done 2 cycles after accept; esp_cmd=4'h2, esp_wdata=32'h000ffffb.
- POP with esp_in=32'h000ffffb, mem_rdata=32'hdeadbeef, ack after 3 waits -> read at 32'h000ffffb; pop_data=32'hdeadbeef; esp_wdata=32'h000fffff.
- POP with esp_in=32'h000fffff -> fault_code=10 in T+1; no mem_req; esp_cmd stays 0.
- PUSH with esp_in=32'h000f0003 -> fault_code=01. PUSH with esp_in=32'h000f0004 -> write at 32'h000f0000.
- op_code=2'b11 -> fault_code=11. Stray mem_ack in IDLE -> no state change.
- reset=0 asserted while in MEM -> mem_req low after the next edge, no done, no esp_cmd. A subsequent PUSH completes normally.
